// File: rtl/sim_test_controller.sv
// Test controller wrapping the core: sequences core reset, watches stores for a tohost verdict, enforces a timeout.
// Optional running store checksum output enabled by defining SIM_TEST_CONTROLLER_CHECKSUM_EN.
module sim_test_controller #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                CYC_W        = 32,
    parameter int                RESET_CYCLES = 4,
    parameter int                MAX_CYCLES   = 5000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h0000_00FC,
    parameter bit                HALT_ON_DONE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_to_mem,
    input  logic [ADDR_W-1:0] address_to_mem,
    input  logic              write_enable,
    output logic              core_reset,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] exit_code,
    output logic [CYC_W-1:0]  cycle_count,
`ifdef SIM_TEST_CONTROLLER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [CYC_W-1:0]  store_count
);

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    localparam logic [7:0]       LP_HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam bit               LP_TO_EN     = (MAX_CYCLES != 0);
    localparam logic [CYC_W-1:0] LP_CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

    logic [2:0] r_state;
    logic [7:0] r_hold_cnt;
    logic       w_run_store;
    logic       w_tohost;
    logic       w_expire;

    assign w_run_store = (r_state == S_RUN) && write_enable;
    assign w_tohost    = w_run_store && (address_to_mem == TOHOST_ADDR);
    assign w_expire    = LP_TO_EN && (cycle_count == LP_CYC_LAST);

    // Tohost verdicts are checked before the timeout so a coincident store always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            core_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
            store_count <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (r_hold_cnt == LP_HOLD_LAST) begin
                        r_state    <= S_RUN;
                        core_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (write_enable && (store_count != '1)) begin
                        store_count <= store_count + 1'b1;
                    end
                    if (w_tohost && (data_to_mem == DATA_W'(1))) begin
                        r_state    <= S_PASS;
                        done       <= 1'b1;
                        pass       <= 1'b1;
                        core_reset <= HALT_ON_DONE;
                    end else if (w_tohost && (data_to_mem != '0)) begin
                        r_state    <= S_FAIL;
                        done       <= 1'b1;
                        fail       <= 1'b1;
                        exit_code  <= data_to_mem >> 1;
                        core_reset <= HALT_ON_DONE;
                    end else if (w_expire) begin
                        r_state    <= S_TIMEOUT;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                        core_reset <= HALT_ON_DONE;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

`ifdef SIM_TEST_CONTROLLER_CHECKSUM_EN
    // Rotate-left-1 then XOR every RUN store, the tohost store included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (w_run_store) begin
            checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ data_to_mem;
        end
    end
`endif

endmodule

// File: tb/tb_sim_test_controller.sv
// Directed scoreboard bench for sim_test_controller (MAX_CYCLES=20, RESET_CYCLES=4, tohost 0xFC).
// Honors SIM_TEST_CONTROLLER_CHECKSUM_EN to also check the store checksum.
module tb_sim_test_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_to_mem = '0;
    logic [31:0] address_to_mem = '0;
    logic        write_enable = 1'b0;
    logic        core_reset, done, pass, fail, timeout;
    logic [31:0] exit_code, cycle_count, store_count;
`ifdef SIM_TEST_CONTROLLER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int compareCount = 0;
    int mismatchCount = 0;

    typedef struct {
        logic        done, pass, fail, timeout, coreReset;
        logic [31:0] exitCode, cycleCount, storeCount;
    } expT;
    expT sbQ[$];

    always #5 clk = ~clk;

    sim_test_controller #(.MAX_CYCLES(20)) dut (
        .clk(clk), .reset(reset),
        .data_to_mem(data_to_mem), .address_to_mem(address_to_mem), .write_enable(write_enable),
        .core_reset(core_reset), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .exit_code(exit_code), .cycle_count(cycle_count),
`ifdef SIM_TEST_CONTROLLER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .store_count(store_count)
    );

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expectState(input logic d, p, f, t, cr, input logic [31:0] ec, cc, sc);
        expT e;
        e.done = d; e.pass = p; e.fail = f; e.timeout = t; e.coreReset = cr;
        e.exitCode = ec; e.cycleCount = cc; e.storeCount = sc;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        if (sbQ.size() == 0) begin
            compareCount++;
            mismatchCount++;
            $error("[TB] FAIL %s observed=empty-scoreboard expected=entry", tag);
            return;
        end
        e = sbQ.pop_front();
        checkField({tag, ".done"}, 32'(done), 32'(e.done));
        checkField({tag, ".pass"}, 32'(pass), 32'(e.pass));
        checkField({tag, ".fail"}, 32'(fail), 32'(e.fail));
        checkField({tag, ".timeout"}, 32'(timeout), 32'(e.timeout));
        checkField({tag, ".core_reset"}, 32'(core_reset), 32'(e.coreReset));
        checkField({tag, ".exit_code"}, exit_code, e.exitCode);
        checkField({tag, ".cycle_count"}, cycle_count, e.cycleCount);
        checkField({tag, ".store_count"}, store_count, e.storeCount);
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        write_enable   = we;
        address_to_mem = addr;
        data_to_mem    = data;
        @(negedge clk);
        write_enable   = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b0;
        #2;
        expectState(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Counts cycles with core_reset high starting at the release point; leaves us at the first RUN negedge.
    task automatic waitRun(output int n);
        n = 0;
        while (core_reset && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] csStep(input logic [31:0] c, input logic [31:0] d);
        return {c[30:0], c[31]} ^ d;
    endfunction

    initial begin
        int n;
        logic [31:0] expCs;

        $display("[TB] timeout with no stores");
        resetDut();
        waitRun(n);
        checkField("holdCycles1", n, 4);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkField("runCyclesToTimeout", n, 20);
        expectState(1, 0, 0, 1, 1, 0, 20, 0);
        checkOutput("timeout");
        applyStimulus(1, 32'hFC, 32'h1);
        applyStimulus(0, 0, 0);
        expectState(1, 0, 0, 1, 1, 0, 20, 0);
        checkOutput("timeoutSticky");

        $display("[TB] pass after two stores, HOLD stores ignored");
        write_enable = 1'b1; address_to_mem = 32'hFC; data_to_mem = 32'h7;
        resetDut();
        write_enable = 1'b1;
        waitRun(n);
        write_enable = 1'b0;
        checkField("holdCycles2", n, 4);
        expectState(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("holdStoreIgnored");
        applyStimulus(1, 32'h10, 32'h1);
        applyStimulus(1, 32'h14, 32'h2);
        applyStimulus(1, 32'hFC, 32'h1);
        expectState(1, 1, 0, 0, 1, 0, 3, 3);
        checkOutput("pass");
`ifdef SIM_TEST_CONTROLLER_CHECKSUM_EN
        expCs = csStep(csStep(csStep(32'h0, 32'h1), 32'h2), 32'h1);
        checkField("checksum", checksum, expCs);
`else
        expCs = 32'h0;
`endif

        $display("[TB] fail verdict with exit code");
        resetDut();
        waitRun(n);
        applyStimulus(1, 32'hFC, 32'h7);
        expectState(1, 0, 1, 0, 1, 3, 1, 1);
        checkOutput("fail");
        applyStimulus(1, 32'hFC, 32'h1);
        expectState(1, 0, 1, 0, 1, 3, 1, 1);
        checkOutput("failSticky");

        $display("[TB] tohost store coincident with timeout expiry");
        resetDut();
        waitRun(n);
        for (int i = 0; i < 19; i++) applyStimulus(0, 0, 0);
        expectState(0, 0, 0, 0, 0, 0, 19, 0);
        checkOutput("preExpiry");
        applyStimulus(1, 32'hFC, 32'h1);
        expectState(1, 1, 0, 0, 1, 0, 20, 1);
        checkOutput("coincident");

        $display("[TB] zero tohost, near-miss address, async reset mid-run");
        resetDut();
        waitRun(n);
        applyStimulus(1, 32'hFC, 32'h0);
        expectState(0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("tohostZero");
        applyStimulus(1, 32'h1FC, 32'h1);
        expectState(0, 0, 0, 0, 0, 0, 2, 2);
        checkOutput("addrFullWidth");
        #2;
        reset = 1'b0;
        #1;
        expectState(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("asyncReset");
        @(negedge clk);
        reset = 1'b1;
        waitRun(n);
        checkField("holdCycles3", n, 4);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
